issue_rat_prf_reclaim: RTL and testbench

ISSUE_RAT_PRF_RECLAIM -- requirements
Module: issue_rat_prf_reclaim

---
 rtl/issue_rat_prf_reclaim.sv | 163 ++++++++++++++++
 tb/tb_issue_rat_prf_reclaim.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_rat_prf_reclaim.sv
// Rename in-flight queue: records {new, old} PRF pairs, returns old PRFs on commit and new PRFs on flush.
// Optional macro ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN adds the o_occupancy output.
module issue_rat_prf_reclaim #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_alloc_valid,
    input  logic [5:0]            i_alloc_old_prf,
    input  logic                  i_alloc_old_valid,
    output logic                  o_alloc_ready,
    output logic [5:0]            o_alloc_new_prf,
    input  logic [5:0]            i_acquire_prf,
    input  logic                  i_acquire_valid,
    output logic                  o_acquire_ready,
    input  logic                  i_commit_valid,
    output logic                  o_commit_ready,
    output logic [5:0]            o_redeemed_prf,
    output logic                  o_redeemed_valid,
    input  logic                  i_redeemed_ready,
    input  logic                  i_flush,
    output logic [5:0]            o_abandoned_prf,
    output logic                  o_abandoned_valid,
    input  logic                  i_abandoned_ready,
    output logic                  o_busy
`ifdef ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN
    ,
    output logic [DEPTH_LOG2:0]   o_occupancy
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t                 state_q;
    logic [DEPTH_LOG2:0]    head_q;
    logic [DEPTH_LOG2:0]    tail_q;
    logic [DEPTH_LOG2:0]    walk_q;
    logic                   redeem_valid_q;
    logic [5:0]             redeem_prf_q;

    logic [5:0]             new_mem [DEPTH];
    logic [5:0]             old_mem [DEPTH];
    logic                   ov_mem  [DEPTH];

    logic [DEPTH_LOG2-1:0]  head_idx;
    logic [DEPTH_LOG2-1:0]  tail_idx;
    logic [DEPTH_LOG2-1:0]  walk_idx;
    logic [DEPTH_LOG2:0]    walk_last;
    logic                   full;
    logic                   empty;
    logic                   idle;
    logic                   push;
    logic                   pop;
    logic                   walk_done;

    assign head_idx  = head_q[DEPTH_LOG2-1:0];
    assign tail_idx  = tail_q[DEPTH_LOG2-1:0];
    assign walk_idx  = walk_q[DEPTH_LOG2-1:0];
    assign walk_last = tail_q - PTR_ONE;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[DEPTH_LOG2] != tail_q[DEPTH_LOG2]) && (head_idx == tail_idx);
    assign idle  = (state_q == IDLE);

    // Readies are forced low while reset is held so nothing is granted during reset.
    assign o_alloc_ready   = ~reset & i_acquire_valid & ~full & idle & ~i_flush;
    assign o_alloc_new_prf = i_acquire_prf;
    assign o_acquire_ready = i_alloc_valid & o_alloc_ready;
    assign o_commit_ready  = ~reset & ~empty & idle & ~i_flush
                           & (~redeem_valid_q | i_redeemed_ready);

    assign push      = o_acquire_ready;
    assign pop       = i_commit_valid & o_commit_ready;
    assign walk_done = (state_q == WALK) && i_abandoned_ready && (walk_q == walk_last);

    assign o_redeemed_valid  = redeem_valid_q;
    assign o_redeemed_prf    = redeem_prf_q;
    assign o_abandoned_valid = (state_q == WALK);
    assign o_abandoned_prf   = new_mem[walk_idx];
    assign o_busy            = (state_q == WALK);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_idx == gi[DEPTH_LOG2-1:0])) begin
                    new_mem[gi] <= i_acquire_prf;
                    old_mem[gi] <= i_alloc_old_prf;
                    ov_mem[gi]  <= i_alloc_old_valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            walk_q         <= '0;
            redeem_valid_q <= 1'b0;
            redeem_prf_q   <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (pop) begin
                head_q <= head_q + PTR_ONE;
            end

            // A reload on commit wins over the consumer draining the previous value.
            if (pop && ov_mem[head_idx]) begin
                redeem_valid_q <= 1'b1;
                redeem_prf_q   <= old_mem[head_idx];
            end else if (i_redeemed_ready) begin
                redeem_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (i_flush && !empty) begin
                        state_q <= WALK;
                        walk_q  <= head_q;
                    end
                end
                WALK: begin
                    if (walk_done) begin
                        head_q  <= tail_q;
                        state_q <= IDLE;
                    end else if (i_abandoned_ready) begin
                        walk_q <= walk_q + PTR_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN
    logic [DEPTH_LOG2:0] occ_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else if (walk_done) begin
            occ_q <= '0;
        end else if (push && !pop) begin
            occ_q <= occ_q + PTR_ONE;
        end else if (pop && !push) begin
            occ_q <= occ_q - PTR_ONE;
        end
    end

    assign o_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_issue_rat_prf_reclaim.sv
// Bench for issue_rat_prf_reclaim: directed scenarios then random traffic against a queue-based model.
module tb_issue_rat_prf_reclaim;

    logic       clk;
    logic       reset;
    logic       i_alloc_valid;
    logic [5:0] i_alloc_old_prf;
    logic       i_alloc_old_valid;
    logic       o_alloc_ready;
    logic [5:0] o_alloc_new_prf;
    logic [5:0] i_acquire_prf;
    logic       i_acquire_valid;
    logic       o_acquire_ready;
    logic       i_commit_valid;
    logic       o_commit_ready;
    logic [5:0] o_redeemed_prf;
    logic       o_redeemed_valid;
    logic       i_redeemed_ready;
    logic       i_flush;
    logic [5:0] o_abandoned_prf;
    logic       o_abandoned_valid;
    logic       i_abandoned_ready;
    logic       o_busy;
`ifdef ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN
    logic [4:0] o_occupancy;
`endif

    issue_rat_prf_reclaim #(.DEPTH_LOG2(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_alloc_valid     (i_alloc_valid),
        .i_alloc_old_prf   (i_alloc_old_prf),
        .i_alloc_old_valid (i_alloc_old_valid),
        .o_alloc_ready     (o_alloc_ready),
        .o_alloc_new_prf   (o_alloc_new_prf),
        .i_acquire_prf     (i_acquire_prf),
        .i_acquire_valid   (i_acquire_valid),
        .o_acquire_ready   (o_acquire_ready),
        .i_commit_valid    (i_commit_valid),
        .o_commit_ready    (o_commit_ready),
        .o_redeemed_prf    (o_redeemed_prf),
        .o_redeemed_valid  (o_redeemed_valid),
        .i_redeemed_ready  (i_redeemed_ready),
        .i_flush           (i_flush),
        .o_abandoned_prf   (o_abandoned_prf),
        .o_abandoned_valid (o_abandoned_valid),
        .i_abandoned_ready (i_abandoned_ready),
        .o_busy            (o_busy)
`ifdef ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN
        ,
        .o_occupancy       (o_occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] np;
        logic [5:0] op;
        logic       ov;
    } ent_t;

    // Reference model: in-flight entries oldest first, plus walk position and pending redeem.
    ent_t       mq[$];
    bit         walking;
    int         walk_pos;
    bit         rv;
    logic [5:0] rprf;
    logic [5:0] ab_log[$];

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_alloc_valid     = 1'b0;
        i_alloc_old_prf   = '0;
        i_alloc_old_valid = 1'b0;
        i_acquire_prf     = '0;
        i_acquire_valid   = 1'b0;
        i_commit_valid    = 1'b0;
        i_redeemed_ready  = 1'b0;
        i_flush           = 1'b0;
        i_abandoned_ready = 1'b0;
    endtask

    task automatic cycle();
        bit   e_ar;
        bit   e_aq;
        bit   e_cr;
        bit   hs_commit;
        ent_t e;
        @(negedge clk);
        e_ar = !reset && i_acquire_valid && (mq.size() < 16) && !walking && !i_flush;
        e_aq = i_alloc_valid && e_ar;
        e_cr = !reset && (mq.size() > 0) && !walking && !i_flush && (!rv || i_redeemed_ready);
        chk("alloc_ready", o_alloc_ready, e_ar);
        chk("acquire_ready", o_acquire_ready, e_aq);
        chk("alloc_new_prf", o_alloc_new_prf, i_acquire_prf);
        chk("commit_ready", o_commit_ready, e_cr);
        chk("redeemed_valid", o_redeemed_valid, rv);
        if (rv) chk("redeemed_prf", o_redeemed_prf, rprf);
        chk("abandoned_valid", o_abandoned_valid, walking);
        chk("busy", o_busy, walking);
        if (walking) chk("abandoned_prf", o_abandoned_prf, mq[walk_pos].np);
`ifdef ISSUE_RAT_PRF_RECLAIM_OCCUPANCY_EN
        chk("occupancy", o_occupancy, mq.size());
`endif
        hs_commit = i_commit_valid && e_cr;
        if (e_aq)
            $display("[%0t] alloc new=%0d old=%0d ov=%0d", $time, i_acquire_prf, i_alloc_old_prf, i_alloc_old_valid);
        if (hs_commit)
            $display("[%0t] commit head new=%0d", $time, mq[0].np);
        if (o_redeemed_valid && i_redeemed_ready)
            $display("[%0t] redeem prf=%0d", $time, o_redeemed_prf);
        if (o_abandoned_valid && i_abandoned_ready) begin
            $display("[%0t] abandon prf=%0d", $time, o_abandoned_prf);
            ab_log.push_back(o_abandoned_prf);
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            walking  = 0;
            walk_pos = 0;
            rv       = 0;
        end else begin
            if (i_redeemed_ready) rv = 0;
            if (hs_commit) begin
                e = mq.pop_front();
                if (e.ov) begin
                    rv   = 1;
                    rprf = e.op;
                end
            end
            if (e_aq) mq.push_back('{np: i_acquire_prf, op: i_alloc_old_prf, ov: i_alloc_old_valid});
            if (walking) begin
                if (i_abandoned_ready) begin
                    if (walk_pos == mq.size() - 1) begin
                        mq.delete();
                        walking = 0;
                    end else begin
                        walk_pos++;
                    end
                end
            end else if (i_flush && mq.size() > 0) begin
                walking  = 1;
                walk_pos = 0;
            end
        end
        #1;
    endtask

    task automatic do_alloc(input logic [5:0] np, input logic [5:0] op, input logic ov);
        i_alloc_valid     = 1'b1;
        i_acquire_valid   = 1'b1;
        i_acquire_prf     = np;
        i_alloc_old_prf   = op;
        i_alloc_old_valid = ov;
        cycle();
        idle_inputs();
    endtask

    task automatic do_commit(input logic rdy);
        i_commit_valid   = 1'b1;
        i_redeemed_ready = rdy;
        cycle();
        idle_inputs();
    endtask

    initial begin
        logic [5:0] exp_ab [4];
        checks   = 0;
        errors   = 0;
        walking  = 0;
        walk_pos = 0;
        rv       = 0;
        rprf     = '0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, with readies checked while reset is still held.
        i_acquire_valid = 1'b1;
        i_alloc_valid   = 1'b1;
        cycle();
        idle_inputs();
        reset = 1'b0;
        cycle();

        // Three allocs then three commits; redeem appears one cycle after each commit.
        for (int k = 0; k < 3; k++) do_alloc(6'(2 * k), 6'(10 + k), 1'b1);
        for (int k = 0; k < 3; k++) begin
            do_commit(1'b1);
            chk("redeem_seq", o_redeemed_prf, 10 + k);
        end
        i_redeemed_ready = 1'b1;
        cycle();
        idle_inputs();

        // Alloc with no prior mapping produces no redeem.
        do_alloc(6'd20, 6'd0, 1'b0);
        do_commit(1'b1);
        cycle();

        // Fill to 16, then simultaneous commit and alloc request.
        for (int k = 0; k < 16; k++) do_alloc(6'(30 + k), 6'(k), 1'b1);
        i_alloc_valid    = 1'b1;
        i_acquire_valid  = 1'b1;
        i_acquire_prf    = 6'd50;
        i_commit_valid   = 1'b1;
        i_redeemed_ready = 1'b1;
        chk("full_no_alloc", o_alloc_ready, 1'b0);
        cycle();
        i_commit_valid = 1'b0;
        cycle();
        idle_inputs();
        for (int k = 0; k < 20; k++) do_commit(1'b1);
        i_redeemed_ready = 1'b1;
        cycle();
        idle_inputs();

        // Flush of four entries with a stalling abandon consumer.
        do_alloc(6'd5, 6'd1, 1'b1);
        do_alloc(6'd7, 6'd2, 1'b1);
        do_alloc(6'd9, 6'd3, 1'b1);
        do_alloc(6'd11, 6'd4, 1'b1);
        ab_log.delete();
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_abandoned_ready = (k != 1);
            chk("busy_in_walk", o_busy, 1'b1);
            cycle();
        end
        idle_inputs();
        cycle();
        exp_ab = '{6'd5, 6'd7, 6'd9, 6'd11};
        chk("abandon_count", ab_log.size(), 4);
        for (int k = 0; k < 4 && k < ab_log.size(); k++) chk("abandon_order", ab_log[k], exp_ab[k]);
        chk("empty_after_walk", o_commit_ready, 1'b0);

        // Pending redeem survives a flush walk.
        do_alloc(6'd40, 6'd33, 1'b1);
        do_commit(1'b0);
        do_alloc(6'd41, 6'd34, 1'b1);
        do_alloc(6'd42, 6'd35, 1'b1);
        i_flush = 1'b1;
        cycle();
        i_flush           = 1'b0;
        i_abandoned_ready = 1'b1;
        for (int k = 0; k < 10 && walking; k++) begin
            chk("redeem_held", o_redeemed_prf, 6'd33);
            cycle();
        end
        idle_inputs();
        chk("redeem_still_valid", o_redeemed_valid, 1'b1);
        i_redeemed_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Reset mid-walk after two of four abandons.
        for (int k = 0; k < 4; k++) do_alloc(6'(60 + k), 6'(k), 1'b1);
        i_flush = 1'b1;
        cycle();
        i_flush           = 1'b0;
        i_abandoned_ready = 1'b1;
        cycle();
        cycle();
        i_abandoned_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_walk_valid", o_abandoned_valid, 1'b0);
        chk("abort_walk_busy", o_busy, 1'b0);
        cycle();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            i_alloc_valid     = ($urandom % 4) != 0;
            i_acquire_valid   = ($urandom % 3) != 0;
            i_acquire_prf     = 6'($urandom);
            i_alloc_old_prf   = 6'($urandom);
            i_alloc_old_valid = 1'($urandom);
            i_commit_valid    = ($urandom % 3) == 0;
            i_redeemed_ready  = ($urandom % 3) != 0;
            i_flush           = ($urandom % 40) == 0;
            i_abandoned_ready = 1'($urandom);
            reset             = ($urandom % 300) == 0;
            cycle();
        end
        idle_inputs();
        reset = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
